pipe_fwd_chain: RTL and testbench
=================================

// Module: pipe_fwd_chain
// PURPOSE
//  Parametrised in-order result pipeline with built-in operand forwarding and
//  load-use hazard detection. Replaces hand-wired ID/EX..MEM/WB meta registers
//  plus separate forwarding and hazard units. Stage 0 is youngest; stage
//  STAGES-1 drives register-file writeback. Feeds NUM_SRC operand lookups per cycle.
// PARAMETERS
//  STAGES     3   pipeline depth after decode, >=2
//  DATA_W     32  result width
//  RD_W       5   destination register index width; index 0 never forwards
//  PAY_W      16  opaque payload carried alongside each entry
//  NUM_SRC    2   number of parallel forwarding lookups
//  FILL_STAGE 2   stage whose entry receives the late (memory) result, 1..STAGES-1
// PORTS
//  clk          in   1               rising-edge clock
//  rst          in   1               synchronous, active-high reset
//  en           in   1               1 = chain shifts this cycle; 0 = freeze
//  in_valid     in   1               entry offered to stage 0; 0 = bubble
//  in_wen       in   1               entry writes a register
//  in_rd        in   RD_W            destination register
//  in_res       in   DATA_W          early result
//  in_res_rdy   in   1               in_res valid now; 0 = result arrives via fill
//  in_pay       in   PAY_W           payload
//  flush_mask   in   STAGES          bit s kills stage s on this edge
//  fill_en      in   1               late result present for entry leaving stage FILL_STAGE-1
//  fill_data    in   DATA_W          late result value
//  q_rd         in   NUM_SRC*RD_W    lookup register indices, lane i at [i*RD_W +: RD_W]
//  q_hit        out  NUM_SRC         lane i matches an in-flight writer
//  q_data       out  NUM_SRC*DATA_W  forwarded value for lane i
//  q_stall      out  NUM_SRC         youngest matching writer has no result yet
//  wb_valid     out  1               stage STAGES-1 occupied
//  wb_wen       out  1               stage STAGES-1 writes register (qualified by wb_valid)
//  wb_rd        out  RD_W            writeback index
//  wb_res       out  DATA_W          writeback value
//  wb_pay       out  PAY_W           writeback payload
//  occ          out  $clog2(STAGES+1) count of valid stages
//  err          out  1               sticky: writer reached stage FILL_STAGE without result
// BEHAVIOUR
//  - Per stage: valid, wen, rd, res, rdy, pay registers.
//  - Reset: all valid=0, rdy=0, wen=0, rd=0, res=0, pay=0, err=0. Thus q_hit=0,
//    q_stall=0, q_data=0, wb_valid=0, occ=0 one cycle after rst; rst beats en/flush.
//  - en=1 edge: stage s <= stage s-1 for s>=1; stage 0 <= in_*. Last stage drops out.
//  - en=0 edge: contents hold; inputs in_* and fill_* ignored.
//  - flush_mask[s]=1: stage s's NEW valid is 0 after the edge (en=1: the entry
//    shifting into s dies; en=0: entry held in s dies). Flush beats fill.
//  - Fill: on en=1, entry moving from FILL_STAGE-1 into FILL_STAGE with rdy=0 takes
//    res=fill_data, rdy=1 if fill_en=1. fill_en ignored if that entry has rdy=1
//    or valid=0. If valid&wen&!rdy entry enters FILL_STAGE without fill_en: err<=1.
//  - Lookup (combinational, zero latency): candidate stage s matches lane i when
//    valid&wen&(rd==q_rd_i)&(q_rd_i!=0). Youngest (lowest s) match wins.
//    q_hit=1 on any match; q_data=winner.res if winner.rdy else 0;
//    q_stall = winner exists & !winner.rdy. Older matches never override stall.
//  - Lookup does not include in_* (decoded but not yet entered entry).
//  - wb_* are direct register outputs of stage STAGES-1; wb_res valid only when rdy.
//  - occ = popcount(valid), registered semantics (reflects current stage contents).
//  - Caller inserts bubble (in_valid=0) while any q_stall=1; chain never self-stalls.
// TESTING
//  1 rst=1 two cycles with in_valid=1 -> wb_valid=0, occ=0, q_hit=0, err=0.
//  2 Enter wen rd=5 res=0x11 rdy=1, en=1; next cycle q_rd=5 -> q_hit=1,
//    q_data=0x11, q_stall=0; after STAGES edges wb_rd=5 wb_res=0x11.
//  3 Enter rd=7 res=0xA rdy=1 then rd=7 res=0xB rdy=1 -> q_rd=7 returns 0xB (youngest);
//    q_rd=0 with writer rd=0 in flight -> q_hit=0.
//  4 Load: rd=9 rdy=0 -> q_stall=1 until it leaves FILL_STAGE-1 with fill_en=1,
//    fill_data=0xDEAD -> q_stall=0, q_data=0xDEAD, err stays 0; repeat without fill_en -> err=1.
//  5 Three valid entries, flush_mask=3'b011 with en=1 -> occ=1 after edge;
//    repeat with en=0 -> held entries in stages 0,1 die, stage 2 kept.
//  6 en=0 for 4 cycles while toggling in_*/fill_* -> all outputs unchanged; rst mid-freeze clears all.

Source files
------------

// File: rtl/pipe_fwd_chain.sv
// In-order result pipeline with operand forwarding and late-result fill.
// Stage 0 is youngest; stage STAGES-1 drives register-file writeback.
module pipe_fwd_chain #(
  parameter int STAGES     = 3,
  parameter int DATA_W     = 32,
  parameter int RD_W       = 5,
  parameter int PAY_W      = 16,
  parameter int NUM_SRC    = 2,
  parameter int FILL_STAGE = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          in_valid,
  input  logic                          in_wen,
  input  logic [RD_W-1:0]               in_rd,
  input  logic [DATA_W-1:0]             in_res,
  input  logic                          in_res_rdy,
  input  logic [PAY_W-1:0]              in_pay,
  input  logic [STAGES-1:0]             flush_mask,
  input  logic                          fill_en,
  input  logic [DATA_W-1:0]             fill_data,
  input  logic [NUM_SRC*RD_W-1:0]       q_rd,
  output logic [NUM_SRC-1:0]            q_hit,
  output logic [NUM_SRC*DATA_W-1:0]     q_data,
  output logic [NUM_SRC-1:0]            q_stall,
  output logic                          wb_valid,
  output logic                          wb_wen,
  output logic [RD_W-1:0]               wb_rd,
  output logic [DATA_W-1:0]             wb_res,
  output logic [PAY_W-1:0]              wb_pay,
  output logic [$clog2(STAGES+1)-1:0]   occ,
  output logic                          err
);

  localparam int OCC_W = $clog2(STAGES+1);

  logic [STAGES-1:0] st_v;
  logic [STAGES-1:0] st_wen;
  logic [STAGES-1:0] st_rdy;
  logic [RD_W-1:0]   st_rd  [STAGES];
  logic [DATA_W-1:0] st_res [STAGES];
  logic [PAY_W-1:0]  st_pay [STAGES];
  logic              err_q;
  logic              fill_hit;
  logic              fill_miss;

  // A flushed entry neither takes the fill nor raises err: it is gone.
  assign fill_hit  = st_v[FILL_STAGE-1] & ~st_rdy[FILL_STAGE-1] & fill_en
                   & ~flush_mask[FILL_STAGE];
  assign fill_miss = st_v[FILL_STAGE-1] & st_wen[FILL_STAGE-1] & ~st_rdy[FILL_STAGE-1]
                   & ~fill_en & ~flush_mask[FILL_STAGE];

  always_ff @(posedge clk) begin
    if (rst) begin
      st_v   <= '0;
      st_wen <= '0;
      st_rdy <= '0;
      err_q  <= 1'b0;
      for (int unsigned s = 0; s < STAGES; s++) begin
        st_rd[s]  <= '0;
        st_res[s] <= '0;
        st_pay[s] <= '0;
      end
    end else if (en) begin
      st_v   <= {st_v[STAGES-2:0], in_valid} & ~flush_mask;
      st_wen <= {st_wen[STAGES-2:0], in_wen};
      st_rdy <= {st_rdy[STAGES-2:0], in_res_rdy};
      st_rd[0]  <= in_rd;
      st_res[0] <= in_res;
      st_pay[0] <= in_pay;
      for (int unsigned s = 1; s < STAGES; s++) begin
        st_rd[s]  <= st_rd[s-1];
        st_res[s] <= st_res[s-1];
        st_pay[s] <= st_pay[s-1];
      end
      if (fill_hit) begin
        st_res[FILL_STAGE] <= fill_data;
        st_rdy[FILL_STAGE] <= 1'b1;
      end
      if (fill_miss) err_q <= 1'b1;
    end else begin
      st_v <= st_v & ~flush_mask;
    end
  end

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    q_hit   = '0;
    q_stall = '0;
    q_data  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (st_v[STAGES-1-k] && st_wen[STAGES-1-k] &&
            (st_rd[STAGES-1-k] == q_rd[i*RD_W +: RD_W]) &&
            (q_rd[i*RD_W +: RD_W] != '0)) begin
          q_hit[i]                  = 1'b1;
          q_stall[i]                = ~st_rdy[STAGES-1-k];
          q_data[i*DATA_W +: DATA_W] = st_rdy[STAGES-1-k] ? st_res[STAGES-1-k] : '0;
        end
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      if (st_v[s]) occ = occ + OCC_W'(1);
    end
  end

  assign wb_valid = st_v[STAGES-1];
  assign wb_wen   = st_wen[STAGES-1];
  assign wb_rd    = st_rd[STAGES-1];
  assign wb_res   = st_res[STAGES-1];
  assign wb_pay   = st_pay[STAGES-1];
  assign err      = err_q;

endmodule

// File: tb/tb_pipe_fwd_chain.sv
// Bench for pipe_fwd_chain: directed scenarios plus random traffic, all
// checked against a queue-based reference model of the chain.
module tb_pipe_fwd_chain;

  localparam int STAGES     = 3;
  localparam int DATA_W     = 32;
  localparam int RD_W       = 5;
  localparam int PAY_W      = 16;
  localparam int NUM_SRC    = 2;
  localparam int FILL_STAGE = 2;
  localparam int OCC_W      = $clog2(STAGES+1);

  logic                      clk;
  logic                      rst;
  logic                      en;
  logic                      in_valid;
  logic                      in_wen;
  logic [RD_W-1:0]           in_rd;
  logic [DATA_W-1:0]         in_res;
  logic                      in_res_rdy;
  logic [PAY_W-1:0]          in_pay;
  logic [STAGES-1:0]         flush_mask;
  logic                      fill_en;
  logic [DATA_W-1:0]         fill_data;
  logic [NUM_SRC*RD_W-1:0]   q_rd;
  logic [NUM_SRC-1:0]        q_hit;
  logic [NUM_SRC*DATA_W-1:0] q_data;
  logic [NUM_SRC-1:0]        q_stall;
  logic                      wb_valid;
  logic                      wb_wen;
  logic [RD_W-1:0]           wb_rd;
  logic [DATA_W-1:0]         wb_res;
  logic [PAY_W-1:0]          wb_pay;
  logic [OCC_W-1:0]          occ;
  logic                      err;

  pipe_fwd_chain #(
    .STAGES(STAGES), .DATA_W(DATA_W), .RD_W(RD_W), .PAY_W(PAY_W),
    .NUM_SRC(NUM_SRC), .FILL_STAGE(FILL_STAGE)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(in_valid), .in_wen(in_wen), .in_rd(in_rd), .in_res(in_res),
    .in_res_rdy(in_res_rdy), .in_pay(in_pay), .flush_mask(flush_mask),
    .fill_en(fill_en), .fill_data(fill_data), .q_rd(q_rd),
    .q_hit(q_hit), .q_data(q_data), .q_stall(q_stall),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_res(wb_res),
    .wb_pay(wb_pay), .occ(occ), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit              v;
    bit              wen;
    bit              rdy;
    bit [RD_W-1:0]   rd;
    bit [DATA_W-1:0] res;
    bit [PAY_W-1:0]  pay;
  } ent_t;

  ent_t mp[$];   // mp[0] = youngest
  bit   m_err;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t blank();
    ent_t e;
    e.v = 0; e.wen = 0; e.rdy = 0; e.rd = '0; e.res = '0; e.pay = '0;
    return e;
  endfunction

  task automatic kill(input int s);
    ent_t e;
    e = mp[s];
    e.v = 0;
    mp[s] = e;
  endtask

  task automatic model_edge();
    ent_t e;
    if (rst) begin
      mp.delete();
      for (int s = 0; s < STAGES; s++) mp.push_back(blank());
      m_err = 0;
    end else if (en) begin
      e.v = in_valid; e.wen = in_wen; e.rdy = in_res_rdy;
      e.rd = in_rd; e.res = in_res; e.pay = in_pay;
      mp.push_front(e);
      void'(mp.pop_back());
      e = mp[FILL_STAGE];
      if (e.v && !e.rdy && !flush_mask[FILL_STAGE]) begin
        if (fill_en) begin
          e.res = fill_data;
          e.rdy = 1;
          mp[FILL_STAGE] = e;
        end else if (e.wen) begin
          m_err = 1;
        end
      end
      for (int s = 0; s < STAGES; s++) if (flush_mask[s]) kill(s);
    end else begin
      for (int s = 0; s < STAGES; s++) if (flush_mask[s]) kill(s);
    end
  endtask

  function automatic void look(input bit [RD_W-1:0] r, output bit h, output bit st,
                               output bit [DATA_W-1:0] d);
    h = 0; st = 0; d = '0;
    if (r != 0) begin
      for (int s = 0; s < STAGES; s++) begin
        if (mp[s].v && mp[s].wen && mp[s].rd == r) begin
          h  = 1;
          st = !mp[s].rdy;
          d  = mp[s].rdy ? mp[s].res : '0;
          break;
        end
      end
    end
  endfunction

  task automatic check_all();
    int cnt;
    bit h, st;
    bit [DATA_W-1:0] d;
    cnt = 0;
    for (int s = 0; s < STAGES; s++) if (mp[s].v) cnt++;
    chk("occ", 64'(occ), 64'(cnt));
    chk("err", 64'(err), 64'(m_err));
    chk("wb_valid", 64'(wb_valid), 64'(mp[STAGES-1].v));
    if (mp[STAGES-1].v) begin
      chk("wb_wen", 64'(wb_wen), 64'(mp[STAGES-1].wen));
      chk("wb_rd", 64'(wb_rd), 64'(mp[STAGES-1].rd));
      chk("wb_pay", 64'(wb_pay), 64'(mp[STAGES-1].pay));
      if (mp[STAGES-1].rdy) chk("wb_res", 64'(wb_res), 64'(mp[STAGES-1].res));
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      look(q_rd[i*RD_W +: RD_W], h, st, d);
      chk("q_hit", 64'(q_hit[i]), 64'(h));
      chk("q_stall", 64'(q_stall[i]), 64'(st));
      chk("q_data", 64'(q_data[i*DATA_W +: DATA_W]), 64'(d));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    rst = 0; en = 1; in_valid = 0; in_wen = 0; in_rd = '0; in_res = '0;
    in_res_rdy = 0; in_pay = '0; flush_mask = '0; fill_en = 0; fill_data = '0;
  endtask

  task automatic put(input logic [RD_W-1:0] rd, input logic [DATA_W-1:0] res, input logic rdy);
    idle();
    in_valid = 1; in_wen = 1; in_rd = rd; in_res = res; in_res_rdy = rdy;
    in_pay = PAY_W'($urandom);
  endtask

  task automatic setq(input logic [RD_W-1:0] a, input logic [RD_W-1:0] b);
    q_rd = {b, a};
  endtask

  initial begin
    idle();
    setq(5'd0, 5'd0);

    // reset held with a valid offer
    rst = 1; in_valid = 1; in_wen = 1; in_rd = 5'd3; in_res_rdy = 1; setq(5'd3, 5'd3);
    step(); step();
    chk("t1_wb_valid", 64'(wb_valid), 64'd0);
    chk("t1_occ", 64'(occ), 64'd0);
    chk("t1_hit", 64'(q_hit), 64'd0);
    chk("t1_err", 64'(err), 64'd0);

    // single forwarded writer then writeback
    put(5'd5, 32'h11, 1); setq(5'd5, 5'd0);
    step();
    chk("t2_hit", 64'(q_hit[0]), 64'd1);
    chk("t2_data", 64'(q_data[DATA_W-1:0]), 64'h11);
    chk("t2_stall", 64'(q_stall[0]), 64'd0);
    idle();
    for (int k = 1; k < STAGES; k++) step();
    chk("t2_wb_valid", 64'(wb_valid), 64'd1);
    chk("t2_wb_rd", 64'(wb_rd), 64'd5);
    chk("t2_wb_res", 64'(wb_res), 64'h11);

    // youngest writer wins; rd 0 never forwards
    setq(5'd7, 5'd0);
    put(5'd7, 32'hA, 1); step();
    put(5'd7, 32'hB, 1); step();
    chk("t3_young", 64'(q_data[DATA_W-1:0]), 64'hB);
    put(5'd0, 32'h55, 1); step();
    chk("t3_rd0", 64'(q_hit[1]), 64'd0);
    chk("t3_young2", 64'(q_data[DATA_W-1:0]), 64'hB);

    // load filled on time, then a load that misses its fill
    idle();
    for (int k = 0; k < STAGES; k++) step();
    setq(5'd9, 5'd9);
    put(5'd9, 32'h1234, 0); step();
    chk("t4_stall0", 64'(q_stall[0]), 64'd1);
    idle(); step();
    chk("t4_stall1", 64'(q_stall[1]), 64'd1);
    idle(); fill_en = 1; fill_data = 32'hDEAD; step();
    chk("t4_stall2", 64'(q_stall[0]), 64'd0);
    chk("t4_data", 64'(q_data[DATA_W-1:0]), 64'hDEAD);
    chk("t4_err0", 64'(err), 64'd0);
    idle(); step();
    put(5'd9, 32'h1234, 0); step();
    idle(); step();
    idle(); step();
    chk("t4_err1", 64'(err), 64'd1);
    chk("t4_miss_stall", 64'(q_stall[0]), 64'd1);

    // flushes while shifting and while frozen
    idle(); rst = 1; step();
    setq(5'd2, 5'd4);
    put(5'd1, 32'h1, 1); step();
    put(5'd2, 32'h2, 1); step();
    put(5'd3, 32'h3, 1); step();
    idle(); flush_mask = 3'b011; step();
    chk("t5_occ_en", 64'(occ), 64'd1);
    chk("t5_wb_rd_en", 64'(wb_rd), 64'd2);
    put(5'd4, 32'h4, 1); step();
    put(5'd5, 32'h5, 1); step();
    put(5'd6, 32'h6, 1); step();
    idle(); en = 0; flush_mask = 3'b011; step();
    chk("t5_occ_hold", 64'(occ), 64'd1);
    chk("t5_wb_rd_hold", 64'(wb_rd), 64'd4);

    // freeze ignores in_*/fill_*, reset clears mid-freeze
    put(5'd8, 32'h80, 1); step();
    put(5'd9, 32'h90, 0); step();
    put(5'd10, 32'hA0, 1); step();
    for (int k = 0; k < 4; k++) begin
      en = 0; in_valid = 1; in_wen = 1; in_rd = RD_W'($urandom_range(1, 15));
      in_res = $urandom; in_res_rdy = 1; fill_en = 1; fill_data = $urandom;
      setq(5'd9, 5'd10);
      step();
      chk("t6_occ", 64'(occ), 64'd3);
      chk("t6_wb_rd", 64'(wb_rd), 64'd8);
    end
    en = 0; rst = 1; step();
    chk("t6_rst_occ", 64'(occ), 64'd0);
    chk("t6_rst_wb", 64'(wb_valid), 64'd0);
    chk("t6_rst_hit", 64'(q_hit), 64'd0);

    // random traffic
    for (int k = 0; k < 500; k++) begin
      rst        = ($urandom_range(0, 99) == 0);
      en         = ($urandom_range(0, 4) != 0);
      in_valid   = 1'($urandom);
      in_wen     = ($urandom_range(0, 3) != 0);
      in_rd      = RD_W'($urandom_range(0, 7));
      in_res     = $urandom;
      in_res_rdy = 1'($urandom);
      in_pay     = PAY_W'($urandom);
      flush_mask = ($urandom_range(0, 7) == 0) ? STAGES'($urandom) : '0;
      fill_en    = 1'($urandom);
      fill_data  = $urandom;
      setq(RD_W'($urandom_range(0, 7)), RD_W'($urandom_range(0, 7)));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
